// File: rtl/mcpu_ctrl_pkg.sv
// Shared definitions (mcpu_defs) for the multi-cycle MIPS control unit: ALU codes,
// opcode/funct codes, state encodings and mux selects. Optional macro: MCPU_OVF_TRAP_EN.
package mcpu_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_R_WB     = 4'd3,
    S_EX_I     = 4'd4,
    S_I_WB     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_LW_WB    = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BR       = 4'd10,
    S_J        = 4'd11,
    S_JAL      = 4'd12,
`ifdef MCPU_OVF_TRAP_EN
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
`else
    S_JR       = 4'd13
`endif
  } state_e;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS    = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;
  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BOFS  = 2'b11;
  localparam logic [1:0] DST_RT     = 2'b00;
  localparam logic [1:0] DST_RD     = 2'b01;
  localparam logic [1:0] DST_RA     = 2'b10;
  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MDR     = 2'b01;
  localparam logic [1:0] WB_PC      = 2'b10;
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  localparam logic [1:0] PC_RS      = 2'b11;

  function automatic logic is_shift(input logic [5:0] func);
    return (func == FN_SLL) || (func == FN_SRL) || (func == FN_SRA);
  endfunction

`ifdef MCPU_OVF_TRAP_EN
  // Only the signed arithmetic forms can raise an overflow trap.
  function automatic logic is_ovf_op(input logic [5:0] op, input logic [5:0] func);
    return (op == OP_ADDI) || ((op == OP_RTYPE) && ((func == FN_ADD) || (func == FN_SUB)));
  endfunction
`endif

endpackage

// File: rtl/mcpu_ctrl_alu_decode.sv
// ALU function select decoded from {state, OP, Func}; shared with the datapath bench.
module mcpu_ctrl_alu_decode
  import mcpu_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] OP,
  input  logic [5:0] Func,
  output logic [3:0] ALU_operation
);

  logic [3:0] r_op_s;
  logic [3:0] i_op_s;

  // R-type funct field to ALU code; unmapped functs fall back to ADD
  always_comb begin
    r_op_s = ALU_ADD;
    case (Func)
      FN_ADD, FN_ADDU: r_op_s = ALU_ADD;
      FN_SUB, FN_SUBU: r_op_s = ALU_SUB;
      FN_AND:          r_op_s = ALU_AND;
      FN_OR:           r_op_s = ALU_OR;
      FN_XOR:          r_op_s = ALU_XOR;
      FN_NOR:          r_op_s = ALU_NOR;
      FN_SLT:          r_op_s = ALU_SLT;
      FN_SLTU:         r_op_s = ALU_SLTU;
      FN_SLL:          r_op_s = ALU_SLL;
      FN_SRL:          r_op_s = ALU_SRL;
      FN_SRA:          r_op_s = ALU_SRA;
      default:         r_op_s = ALU_ADD;
    endcase
  end

  // Immediate-form opcode to ALU code
  always_comb begin
    i_op_s = ALU_ADD;
    case (OP)
      OP_ADDI: i_op_s = ALU_ADD;
      OP_SLTI: i_op_s = ALU_SLT;
      OP_ANDI: i_op_s = ALU_AND;
      OP_ORI:  i_op_s = ALU_OR;
      OP_XORI: i_op_s = ALU_XOR;
      OP_LUI:  i_op_s = ALU_LUI;
      default: i_op_s = ALU_ADD;
    endcase
  end

  // Per-state select; fetch, decode and address phases all add
  always_comb begin
    ALU_operation = ALU_ADD;
    case (state)
      S_EX_R:  ALU_operation = r_op_s;
      S_EX_I:  ALU_operation = i_op_s;
      S_BR:    ALU_operation = ALU_SUB;
      default: ALU_operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control FSM driving the ALU select and datapath enables.
// Optional overflow trap path enabled by macro MCPU_OVF_TRAP_EN.
module mcpu_ctrl
  import mcpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         OP,
  input  logic [5:0]         Func,
  input  logic               zero,
  input  logic               overflow,
  input  logic               MIO_ready,
  output logic [3:0]         ALU_operation,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               SignedExt,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               Branch_ne,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         PCSource,
`ifdef MCPU_OVF_TRAP_EN
  output logic               trap,
`endif
  output logic [STATE_W-1:0] state
);

  state_e state_r;
  state_e state_nxt_s;
  logic   unused_s;

  // zero is consumed by the datapath branch logic, not by the sequencer
`ifdef MCPU_OVF_TRAP_EN
  assign unused_s = zero;
`else
  assign unused_s = ^{zero, overflow};
`endif

  assign state = state_r;

  mcpu_ctrl_alu_decode u_alu_decode (
    .state         (state_r),
    .OP            (OP),
    .Func          (Func),
    .ALU_operation (ALU_operation)
  );

  // State register; reset returns to fetch immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IF;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and Moore control decode
  always_comb begin
    state_nxt_s = S_IF;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    SignedExt   = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch_ne   = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = DST_RT;
    MemtoReg    = WB_ALU;
    PCSource    = PC_ALU;
`ifdef MCPU_OVF_TRAP_EN
    trap        = 1'b0;
`endif
    case (state_r)
      S_IF: begin
        MemRead     = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        IRWrite     = MIO_ready;
        PCWrite     = MIO_ready;
        state_nxt_s = MIO_ready ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrcB = SRCB_BOFS;
        case (OP)
          OP_RTYPE:                state_nxt_s = (Func == FN_JR) ? S_JR : S_EX_R;
          OP_LW, OP_SW:            state_nxt_s = S_MEM_ADDR;
          OP_BEQ, OP_BNE:          state_nxt_s = S_BR;
          OP_ADDI, OP_SLTI, OP_ANDI,
          OP_ORI, OP_XORI, OP_LUI: state_nxt_s = S_EX_I;
          OP_J:                    state_nxt_s = S_J;
          OP_JAL:                  state_nxt_s = S_JAL;
          default:                 state_nxt_s = S_IF;
        endcase
      end
      S_EX_R: begin
        ALUSrcA     = is_shift(Func) ? SRCA_SHAMT : SRCA_RS;
        state_nxt_s = S_R_WB;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = DST_RD;
`ifdef MCPU_OVF_TRAP_EN
        if (overflow && is_ovf_op(OP, Func)) begin
          RegWrite    = 1'b0;
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = S_IF;
        end
`else
        state_nxt_s = S_IF;
`endif
      end
      S_EX_I: begin
        ALUSrcA     = SRCA_RS;
        ALUSrcB     = SRCB_IMM;
        SignedExt   = ((OP == OP_ANDI) || (OP == OP_ORI) || (OP == OP_XORI)) ? 1'b0 : 1'b1;
        state_nxt_s = S_I_WB;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        RegDst   = DST_RT;
`ifdef MCPU_OVF_TRAP_EN
        if (overflow && is_ovf_op(OP, Func)) begin
          RegWrite    = 1'b0;
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = S_IF;
        end
`else
        state_nxt_s = S_IF;
`endif
      end
      S_MEM_ADDR: begin
        ALUSrcA     = SRCA_RS;
        ALUSrcB     = SRCB_IMM;
        SignedExt   = 1'b1;
        state_nxt_s = (OP == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD        = 1'b1;
        MemRead     = 1'b1;
        state_nxt_s = MIO_ready ? S_LW_WB : S_MEM_RD;
      end
      S_LW_WB: begin
        RegWrite    = 1'b1;
        MemtoReg    = WB_MDR;
        RegDst      = DST_RT;
        state_nxt_s = S_IF;
      end
      S_MEM_WR: begin
        IorD        = 1'b1;
        MemWrite    = 1'b1;
        state_nxt_s = MIO_ready ? S_IF : S_MEM_WR;
      end
      S_BR: begin
        ALUSrcA     = SRCA_RS;
        ALUSrcB     = SRCB_RT;
        PCSource    = PC_ALUOUT;
        PCWriteCond = 1'b1;
        Branch_ne   = (OP == OP_BNE) ? 1'b1 : 1'b0;
        state_nxt_s = S_IF;
      end
      S_J: begin
        PCWrite     = 1'b1;
        PCSource    = PC_JUMP;
        state_nxt_s = S_IF;
      end
      S_JAL: begin
        PCWrite     = 1'b1;
        PCSource    = PC_JUMP;
        RegWrite    = 1'b1;
        RegDst      = DST_RA;
        MemtoReg    = WB_PC;
        state_nxt_s = S_IF;
      end
      S_JR: begin
        PCWrite     = 1'b1;
        PCSource    = PC_RS;
        state_nxt_s = S_IF;
      end
`ifdef MCPU_OVF_TRAP_EN
      S_TRAP: begin
        trap        = 1'b1;
        PCWrite     = 1'b1;
        PCSource    = PC_ALUOUT;
        state_nxt_s = S_IF;
      end
`endif
      default: state_nxt_s = S_IF;
    endcase
  end

endmodule
